level_sense: RTL and testbench
==============================

LEVEL_SENSE -- requirements
Module: level_sense

Interface
REQ-001 The block SHALL expose parameter DEB_CYCLES, default 4, range 2..255: consecutive mismatching samples needed to accept a probe change.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port p_crit, input, 1 bit: raw bottom probe, 1 = wet.
REQ-005 The block SHALL have port p_low, input, 1 bit: raw middle probe, 1 = wet.
REQ-006 The block SHALL have port p_high, input, 1 bit: raw top probe, 1 = wet.
REQ-007 The block SHALL have port low, output, 1 bit: tank below middle probe, consumed by the downstream cleaning/supply FSM.
REQ-008 The block SHALL have port critico, output, 1 bit: tank below bottom probe or sensor fault, consumed downstream.
REQ-009 The block SHALL have port full, output, 1 bit: top probe wet.
REQ-010 The block SHALL have port err, output, 1 bit: inconsistent probe pattern.
REQ-011 The block SHALL have port level, output, 3 bits: current state code.

Function
REQ-012 Each probe SHALL have an independent debouncer: 8-bit counter plus filtered bit.
REQ-013 Debouncer on each edge: raw == filtered -> counter cleared; raw != filtered and counter < DEB_CYCLES-1 -> counter +1; raw != filtered and counter == DEB_CYCLES-1 -> filtered <= raw, counter cleared.
REQ-014 A raw glitch shorter than DEB_CYCLES samples SHALL never change the filtered bit; any matching sample restarts the count.
REQ-015 The state register SHALL classify filtered {high,low,crit} on each edge: 000 CRIT, 001 LOW, 011 NORMAL, 111 FULL, any other ERR.
REQ-016 State codes SHALL be CRIT=000, LOW=001, NORMAL=010, FULL=011, ERR=100; level = state.
REQ-017 Outputs SHALL be registered, decoded from state: CRIT -> low=1, critico=1; LOW -> low=1; NORMAL -> all 0; FULL -> full=1; ERR -> err=1, critico=1, low=0, full=0.
REQ-018 Latency: raw change stable before edge k SHALL update filtered at edge k+DEB_CYCLES-1 and outputs at edge k+DEB_CYCLES.
REQ-019 Several probes accepted in the same cycle SHALL be classified together; no intermediate state SHALL appear.
REQ-020 Any state SHALL be able to transition directly to any other state, including CRIT <-> FULL.
REQ-021 Leaving ERR SHALL follow REQ-015 unless the latch feature of REQ-025 is compiled in.

Reset
REQ-022 With reset high at an edge, all filtered bits and counters SHALL clear to 0 and state SHALL become CRIT.
REQ-023 After reset: low=1, critico=1, full=0, err=0, level=000.
REQ-024 Reset SHALL override all debounce activity in progress; no partial count survives.

Configuration
REQ-025 With macro LEVEL_ERR_LATCH_EN defined, ERR SHALL be sticky and exited only by reset; without it, ERR SHALL clear on the edge after a consistent filtered pattern appears.

Verification
REQ-026 The bench SHALL cover reset, then p_crit=p_low=1 held (DEB_CYCLES=4) -> level=010, low=0, critico=0 on the 5th edge after the change.
REQ-027 The bench SHALL cover p_crit=1 pulsed for 3 cycles from reset state -> level stays 000, critico stays 1.
REQ-028 The bench SHALL cover p_high=1 with p_crit=p_low=0 for 4 cycles -> level=100, err=1, critico=1, low=0.
REQ-029 The bench SHALL cover the REQ-028 state, then all probes=1 for 4 cycles -> without macro level=011, full=1, err=0; with LEVEL_ERR_LATCH_EN level remains 100.
REQ-030 The bench SHALL cover full tank (111), then all probes dropped to 0 simultaneously -> after 5 edges level=000 directly, no 001 or 010 seen.
REQ-031 The bench SHALL cover reset asserted 2 cycles into a debounce -> outputs return to CRIT values; a following 3-cycle mismatch does not change filtered.

Source files
------------

// File: rtl/level_sense.sv
// level_sense: tank level classifier fed by three wet/dry probes.
// Each raw probe has its own debouncer (8-bit counter plus filtered bit). The
// filtered pattern {high,low,crit} is classified into CRIT/LOW/NORMAL/FULL/ERR
// every clock, and the flag outputs are registered alongside the state.
// Optional build macro: LEVEL_ERR_LATCH_EN -- when defined, ERR is sticky and
// is left only through reset. When undefined, ERR clears as soon as the
// filtered pattern becomes consistent again.
module level_sense #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p_crit,
  input  logic       p_low,
  input  logic       p_high,
  output logic       low,
  output logic       critico,
  output logic       full,
  output logic       err,
  output logic [2:0] level
);

  typedef enum logic [2:0] {
    ST_CRIT   = 3'b000,
    ST_LOW    = 3'b001,
    ST_NORMAL = 3'b010,
    ST_FULL   = 3'b011,
    ST_ERR    = 3'b100
  } state_t;

  // Terminal count: the DEB_CYCLES-th consecutive mismatching sample is the
  // one that is accepted.
  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  // Bit order everywhere: [2]=high, [1]=low, [0]=crit.
  logic [2:0] raw;
  logic [2:0] filt;

  assign raw = {p_high, p_low, p_crit};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic       filt_q;
      logic       filt_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;

      // Next-state: a matching sample restarts the count; a full run of
      // mismatches accepts the raw value.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = 8'd0;
        if (raw[gi] != filt_q) begin
          if (cnt_q == CNT_MAX) begin
            filt_d = raw[gi];
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      // Debouncer registers; reset discards any partial count.
      always_ff @(posedge clock) begin
        if (reset) begin
          filt_q <= 1'b0;
          cnt_q  <= 8'd0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt[gi] = filt_q;
    end
  endgenerate

  state_t state_q;
  state_t state_d;
  logic   low_q;
  logic   low_d;
  logic   critico_q;
  logic   critico_d;
  logic   full_q;
  logic   full_d;
  logic   err_q;
  logic   err_d;

  // Classify the whole filtered pattern at once, so probes accepted together
  // never produce an intermediate state; flags are decoded from the next state.
  always_comb begin
    unique case (filt)
      3'b000:  state_d = ST_CRIT;
      3'b001:  state_d = ST_LOW;
      3'b011:  state_d = ST_NORMAL;
      3'b111:  state_d = ST_FULL;
      default: state_d = ST_ERR;
    endcase
`ifdef LEVEL_ERR_LATCH_EN
    if (state_q == ST_ERR) begin
      state_d = ST_ERR;
    end
`endif
    low_d     = 1'b0;
    critico_d = 1'b0;
    full_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_d)
      ST_CRIT: begin
        low_d     = 1'b1;
        critico_d = 1'b1;
      end
      ST_LOW:    low_d = 1'b1;
      ST_NORMAL: low_d = 1'b0;
      ST_FULL:   full_d = 1'b1;
      default: begin
        err_d     = 1'b1;
        critico_d = 1'b1;
      end
    endcase
  end

  // State register with registered flag outputs; reset lands in CRIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CRIT;
      low_q     <= 1'b1;
      critico_q <= 1'b1;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      critico_q <= critico_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  assign low     = low_q;
  assign critico = critico_q;
  assign full    = full_q;
  assign err     = err_q;
  assign level   = state_q;

endmodule

// File: tb/tb_level_sense.sv
// tb_level_sense: directed and random stimulus for level_sense, checked with
// immediate assertions against a sample-history reference model.
module tb_level_sense;

  localparam int DEB = 4;

  logic       clock;
  logic       reset;
  logic       p_crit;
  logic       p_low;
  logic       p_high;
  logic       low;
  logic       critico;
  logic       full;
  logic       err;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state: recent raw samples, accepted pattern, state code.
  logic [2:0] hist[$];
  logic [2:0] m_filt;
  logic [2:0] m_st;

  level_sense #(.DEB_CYCLES(DEB)) dut (
    .clock  (clock),
    .reset  (reset),
    .p_crit (p_crit),
    .p_low  (p_low),
    .p_high (p_high),
    .low    (low),
    .critico(critico),
    .full   (full),
    .err    (err),
    .level  (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] classify(input logic [2:0] f);
    case (f)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      3'b011:  return 3'd2;
      3'b111:  return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A probe's accepted value flips once its last DEB raw samples all
  // disagree with it; the state reflects the pattern accepted one edge earlier.
  task automatic model_edge(input logic [2:0] raw, input logic rst);
    logic all_diff;
    if (rst) begin
      hist.delete();
      m_filt = 3'b000;
      m_st   = 3'd0;
    end else begin
`ifdef LEVEL_ERR_LATCH_EN
      if (m_st != 3'd4) m_st = classify(m_filt);
`else
      m_st = classify(m_filt);
`endif
      hist.push_back(raw);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        for (int i = 0; i < 3; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++)
            if (hist[j][i] == m_filt[i]) all_diff = 1'b0;
          if (all_diff) m_filt[i] = ~m_filt[i];
        end
      end
    end
  endtask

  // One clock: drive inputs, clock the DUT and the model, compare all outputs.
  task automatic step(input logic [2:0] raw, input logic rst);
    {p_high, p_low, p_crit} = raw;
    reset = rst;
    @(posedge clock);
    model_edge(raw, rst);
    #1;
    chk("level",   8'(level),   8'(m_st));
    chk("low",     8'(low),     8'(m_st == 3'd0 || m_st == 3'd1));
    chk("critico", 8'(critico), 8'(m_st == 3'd0 || m_st == 3'd4));
    chk("full",    8'(full),    8'(m_st == 3'd3));
    chk("err",     8'(err),     8'(m_st == 3'd4));
    $display("step raw=%b rst=%b level=%0d low=%b critico=%b full=%b err=%b",
             raw, rst, level, low, critico, full, err);
  endtask

  initial begin
    logic [2:0] cur;
    logic [2:0] pats [4];
    int r;
    pats[0] = 3'b000; pats[1] = 3'b001; pats[2] = 3'b011; pats[3] = 3'b111;
    reset = 1'b1;
    {p_high, p_low, p_crit} = 3'b000;
    m_filt = 3'b000;
    m_st = 3'd0;

    // Reset state
    step(3'b000, 1'b1);
    chk("rst_level", 8'(level), 8'd0);
    chk("rst_low", 8'(low), 8'd1);
    chk("rst_critico", 8'(critico), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_err", 8'(err), 8'd0);

    // crit+low wet: NORMAL on the 5th edge, not before
    for (int i = 0; i < 4; i++) step(3'b011, 1'b0);
    chk("normal_early_level", 8'(level), 8'd0);
    step(3'b011, 1'b0);
    chk("normal_level", 8'(level), 8'd2);
    chk("normal_low", 8'(low), 8'd0);
    chk("normal_critico", 8'(critico), 8'd0);

    // 3-cycle glitch on crit from reset is ignored
    step(3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(3'b000, 1'b0);
      chk("glitch_level", 8'(level), 8'd0);
      chk("glitch_critico", 8'(critico), 8'd1);
    end

    // Top only wet: ERR
    step(3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b100, 1'b0);
    chk("err_level", 8'(level), 8'd4);
    chk("err_err", 8'(err), 8'd1);
    chk("err_critico", 8'(critico), 8'd1);
    chk("err_low", 8'(low), 8'd0);

    // All wet afterwards: FULL, unless ERR is sticky
    for (int i = 0; i < 5; i++) step(3'b111, 1'b0);
`ifdef LEVEL_ERR_LATCH_EN
    chk("errexit_level", 8'(level), 8'd4);
`else
    chk("errexit_level", 8'(level), 8'd3);
    chk("errexit_full", 8'(full), 8'd1);
    chk("errexit_err", 8'(err), 8'd0);
`endif

    // FULL to CRIT directly when all probes dry together
    step(3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b111, 1'b0);
    chk("full_level", 8'(level), 8'd3);
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 1'b0);
      chk("drop_no_mid", 8'(level == 3'd1 || level == 3'd2), 8'd0);
    end
    chk("drop_level", 8'(level), 8'd0);

    // Reset mid-debounce discards the partial count
    step(3'b000, 1'b1);
    for (int i = 0; i < 2; i++) step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    chk("midrst_level", 8'(level), 8'd0);
    chk("midrst_low", 8'(low), 8'd1);
    chk("midrst_critico", 8'(critico), 8'd1);
    for (int i = 0; i < 3; i++) step(3'b001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(3'b000, 1'b0);
      chk("midrst_hold", 8'(level), 8'd0);
    end

    // Random: mostly held patterns with glitches, jumps and occasional resets
    cur = 3'b000;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        step(cur, 1'b1);
      end else begin
        if (r < 12) cur = pats[$urandom_range(0, 3)];
        else if (r < 20) cur = 3'($urandom_range(0, 7));
        else if (r < 30) cur[$urandom_range(0, 2)] = ~cur[$urandom_range(0, 2)];
        step(cur, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
